// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle N-bit integer divider (restoring, one quotient bit per clock)
//   producing quotient and remainder for signed or unsigned operands. Acts as
//   the ALU divide/modulo unit; modulo results are taken from R.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle
//   signed_mode  1 = two's-complement operands, sampled with start
//   A            dividend, sampled with start
//   B            divisor, sampled with start
//   busy         high while calculating and during the done cycle
//   done         one-cycle pulse, Q/R/div_by_zero valid
//   Q            quotient, held until the next done
//   R            remainder, held until the next done
//   div_by_zero  set with done when B was zero, held with Q/R
module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [CW-1:0] count;
  logic [N-1:0]  rem;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dsr;
  logic          neg_q;
  logic          neg_r;

  logic [N-1:0]  mag_a;
  logic [N-1:0]  mag_b;
  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic          qbit;
  logic [N-1:0]  rem_next;
  logic [N-1:0]  quo_next;
  logic [N-1:0]  q_final;
  logic [N-1:0]  r_final;

  // Operand magnitudes; negating -2^(N-1) gives 2^(N-1), which is still
  // correct when read as an N-bit unsigned value.
  always_comb begin
    mag_a = (signed_mode && A[N-1]) ? -A : A;
    mag_b = (signed_mode && B[N-1]) ? -B : B;
  end

  // One restoring step. The extra top bit of the trial subtraction is the
  // borrow: clear means the divisor fit and the quotient bit is 1.
  always_comb begin
    shifted  = {rem, dvd[N-1]};
    trial    = shifted - {1'b0, dsr};
    qbit     = ~trial[N];
    rem_next = qbit ? trial[N-1:0] : shifted[N-1:0];
    quo_next = {dvd[N-2:0], qbit};
    q_final  = neg_q ? -quo_next : quo_next;
    r_final  = neg_r ? -rem_next : rem_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = (B == '0) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (count == '0) next_state = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // The dividend register doubles as the quotient accumulator: each step
  // shifts out a dividend bit at the top and shifts in a quotient bit below.
  // Results are written on the edge that enters the done state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rem         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count <= CW'(N - 1);
            rem   <= '0;
            dvd   <= mag_a;
            dsr   <= mag_b;
            neg_q <= signed_mode && (A[N-1] ^ B[N-1]);
            neg_r <= signed_mode && A[N-1];
            if (B == '0) begin
              Q           <= '1;
              R           <= A;
              div_by_zero <= 1'b1;
            end
          end
        end
        S_CALC: begin
          rem   <= rem_next;
          dvd   <= quo_next;
          count <= count - CW'(1);
          if (count == '0) begin
            Q           <= q_final;
            R           <= r_final;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Self-checking bench for seq_divider (N=4). Expected results come from an
//   integer-arithmetic model and are queued when an operation is launched,
//   then popped and compared when done is seen.
module tb_seq_divider;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         signed_mode;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         div_by_zero;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t scoreboard[$];
  int   checks     = 0;
  int   failures   = 0;
  int   done_count = 0;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .Q           (Q),
    .R           (R),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts done pulses; consecutive pulses are always separated by idle.
  always @(posedge done) done_count++;

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic sm);
    exp_t e;
    int   sa, sbv, qi, ri;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      if (sm) begin
        sa  = $signed(a);
        sbv = $signed(b);
      end else begin
        sa  = int'(a);
        sbv = int'(b);
      end
      qi    = sa / sbv;
      ri    = sa % sbv;
      e.q   = qi[N-1:0];
      e.r   = ri[N-1:0];
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Drives a one-cycle start; returns at the negedge of the cycle after the
  // sampling edge.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic sm);
    @(negedge clk);
    A           = a;
    B           = b;
    signed_mode = sm;
    start       = 1'b1;
    scoreboard.push_back(model(a, b, sm));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; lat is the cycle index after the sampling edge.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    start       = 1'b0;
    signed_mode = 1'b0;
    A           = '0;
    B           = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, Q, R, div_by_zero} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_state: busy=%b done=%b Q=%h R=%h dbz=%b, want all 0",
               busy, done, Q, R, div_by_zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    int   lat;
    exp_t e;
    logic [N-1:0] ops [3][2];
    ops[0][0] = 4'd13; ops[0][1] = 4'd3;
    ops[1][0] = 4'd9;  ops[1][1] = 4'd2;
    ops[2][0] = 4'd15; ops[2][1] = 4'd15;
    for (int i = 0; i < 3; i++) begin
      launch(ops[i][0], ops[i][1], 1'b0);
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL unsigned_busy: busy=%b at cycle %0d, want 1", busy, lat);
        end
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat !== 5) begin
        failures++;
        $display("[TB] FAIL unsigned_latency: done at cycle %0d, want 5", lat);
      end
      e = scoreboard.pop_front();
      checks++;
      if ({Q, R, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        failures++;
        $display("[TB] FAIL unsigned_%0d_%0d: Q=%h R=%h dbz=%b, want Q=%h R=%h dbz=%b",
                 ops[i][0], ops[i][1], Q, R, div_by_zero, e.q, e.r, e.dbz);
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL after_done: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_signed;
    int   lat;
    exp_t e;
    logic [N-1:0] ops [4][2];
    ops[0][0] = 4'h9; ops[0][1] = 4'h2;
    ops[1][0] = 4'h8; ops[1][1] = 4'hF;
    ops[2][0] = 4'h7; ops[2][1] = 4'hE;
    ops[3][0] = 4'h8; ops[3][1] = 4'h3;
    for (int i = 0; i < 4; i++) begin
      launch(ops[i][0], ops[i][1], 1'b1);
      wait_done(1, lat);
      checks++;
      if (lat !== 5) begin
        failures++;
        $display("[TB] FAIL signed_latency: done at cycle %0d, want 5", lat);
      end
      e = scoreboard.pop_front();
      checks++;
      if ({Q, R, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        failures++;
        $display("[TB] FAIL signed_%h_%h: Q=%h R=%h dbz=%b, want Q=%h R=%h dbz=%b",
                 ops[i][0], ops[i][1], Q, R, div_by_zero, e.q, e.r, e.dbz);
      end
    end
  endtask

  task automatic test_div_by_zero;
    int   lat;
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      launch(4'h9, 4'h0, m[0]);
      wait_done(1, lat);
      checks++;
      if (lat !== 1) begin
        failures++;
        $display("[TB] FAIL dbz_latency: done at cycle %0d, want 1", lat);
      end
      e = scoreboard.pop_front();
      checks++;
      if ({Q, R, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        failures++;
        $display("[TB] FAIL dbz_mode%0d: Q=%h R=%h dbz=%b, want Q=%h R=%h dbz=%b",
                 m, Q, R, div_by_zero, e.q, e.r, e.dbz);
      end
    end
    launch(4'd6, 4'd4, 1'b0);
    wait_done(1, lat);
    e = scoreboard.pop_front();
    checks++;
    if ({Q, R, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      failures++;
      $display("[TB] FAIL dbz_clear: Q=%h R=%h dbz=%b, want Q=%h R=%h dbz=%b",
               Q, R, div_by_zero, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_ignore_start;
    int   lat;
    int   base;
    exp_t e;
    base = done_count;
    launch(4'd13, 4'd3, 1'b0);
    @(negedge clk);
    A     = 4'd2;
    B     = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A     = 4'd5;
    B     = 4'd0;
    wait_done(3, lat);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("[TB] FAIL ignore_latency: done at cycle %0d, want 5", lat);
    end
    e = scoreboard.pop_front();
    checks++;
    if ({Q, R, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      failures++;
      $display("[TB] FAIL ignore_result: Q=%h R=%h dbz=%b, want Q=%h R=%h dbz=%b",
               Q, R, div_by_zero, e.q, e.r, e.dbz);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (done_count - base !== 1) begin
      failures++;
      $display("[TB] FAIL ignore_done_count: %0d pulses, want 1", done_count - base);
    end
  endtask

  task automatic test_back_to_back;
    int   cnt;
    int   base;
    exp_t e;
    logic [N-1:0] avals [3];
    avals[0] = 4'd13;
    avals[1] = 4'd11;
    avals[2] = 4'd7;
    base = done_count;
    @(negedge clk);
    A           = avals[0];
    B           = 4'd3;
    signed_mode = 1'b0;
    start       = 1'b1;
    scoreboard.push_back(model(avals[0], 4'd3, 1'b0));
    for (int op = 0; op < 3; op++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (done !== 1'b1 && cnt < 20);
      checks++;
      if (cnt !== ((op == 0) ? 5 : 6)) begin
        failures++;
        $display("[TB] FAIL b2b_spacing_%0d: %0d cycles, want %0d",
                 op, cnt, (op == 0) ? 5 : 6);
      end
      e = scoreboard.pop_front();
      checks++;
      if ({Q, R, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        failures++;
        $display("[TB] FAIL b2b_result_%0d: Q=%h R=%h dbz=%b, want Q=%h R=%h dbz=%b",
                 op, Q, R, div_by_zero, e.q, e.r, e.dbz);
      end
      if (op < 2) begin
        A = avals[op+1];
        scoreboard.push_back(model(avals[op+1], 4'd3, 1'b0));
      end else begin
        start = 1'b0;
      end
    end
    repeat (8) @(negedge clk);
    checks++;
    if (done_count - base !== 3) begin
      failures++;
      $display("[TB] FAIL b2b_done_count: %0d pulses, want 3", done_count - base);
    end
  endtask

  task automatic test_reset_mid;
    int   lat;
    int   base;
    exp_t e;
    launch(4'd13, 4'd3, 1'b0);
    e = scoreboard.pop_front();
    base = done_count;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, Q, R, div_by_zero} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid: busy=%b done=%b Q=%h R=%h dbz=%b, want all 0",
               busy, done, Q, R, div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (done_count !== base) begin
      failures++;
      $display("[TB] FAIL reset_no_done: %0d pulses, want 0", done_count - base);
    end
    launch(4'd6, 4'd4, 1'b0);
    wait_done(1, lat);
    e = scoreboard.pop_front();
    checks++;
    if ({Q, R, div_by_zero, lat} !== {e.q, e.r, e.dbz, 32'd5}) begin
      failures++;
      $display("[TB] FAIL reset_recover: Q=%h R=%h dbz=%b lat=%0d, want Q=%h R=%h dbz=%b lat=5",
               Q, R, div_by_zero, lat, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_random;
    int   lat;
    exp_t e;
    logic [N-1:0] a, b;
    logic sm;
    for (int i = 0; i < 24; i++) begin
      a  = N'($urandom_range(0, 15));
      b  = N'($urandom_range(0, 15));
      sm = 1'($urandom_range(0, 1));
      launch(a, b, sm);
      wait_done(1, lat);
      e = scoreboard.pop_front();
      checks++;
      if ({Q, R, div_by_zero, lat} !== {e.q, e.r, e.dbz, (b == '0) ? 32'd1 : 32'd5}) begin
        failures++;
        $display("[TB] FAIL random_%h_%h_s%b: Q=%h R=%h dbz=%b lat=%0d, want Q=%h R=%h dbz=%b",
                 a, b, sm, Q, R, div_by_zero, lat, e.q, e.r, e.dbz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
